tanh_arbiter: RTL
=================

Name: tanh_arbiter

Overview:
- Shares one pipelined tanh unit among NUM_REQ LSTM requesters (e.g. per-lane cell-state activation paths).
- Round-robin arbitration issues at most one sample per cycle into the tanh datapath.
- Each issued sample carries a requester tag through a fixed-latency tag pipeline, and the result returns to the originating requester.
- The tanh unit has no valid/tag of its own; this block is the sole tracker of in-flight work.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- DATA_IN_W, 16: tanh input width, signed 8.8 fixed point.
- DATA_OUT_W, 8: tanh result width.
- TANH_LATENCY, 5: cycles from a sample being presented on tanh_in_data to its result on tanh_out_data.

Ports:
- clock  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = grants allowed; 0 = no new grants, in-flight work drains.
- req_valid  in  NUM_REQ  per-requester sample valid.
- req_data  in  NUM_REQ*DATA_IN_W  per-requester sample; requester i uses bits [i*DATA_IN_W +: DATA_IN_W].
- req_ready  out  NUM_REQ  one-hot grant; handshake = req_valid[i] & req_ready[i].
- tanh_in_data  out  DATA_IN_W  registered sample to the tanh unit.
- tanh_out_data  in  DATA_OUT_W  tanh unit result.
- resp_valid  out  NUM_REQ  one-hot, single-cycle result strobe; no backpressure.
- resp_data  out  DATA_OUT_W  result, valid when any resp_valid bit is set.
- inflight_count  out  $clog2(TANH_LATENCY+2)  samples issued but not yet returned.
- busy  out  1  inflight_count != 0.

Behaviour:

Reset (reset low, asynchronous, effective immediately):
- req_ready = 0, resp_valid = 0, resp_data = 0, tanh_in_data = 0, inflight_count = 0, busy = 0.
- Tag pipeline is cleared; round-robin pointer last_grant = NUM_REQ-1, so requester 0 has top priority first.
- Reset mid-operation discards all in-flight samples. Results the tanh unit emits afterwards are never reported, because the tag pipe is empty.

Arbitration (combinational within the cycle):
- Search order is (last_grant+1) mod NUM_REQ upward, with wrap-around. The first i with req_valid[i] gets req_ready[i] = 1.
- req_ready = 0 for all requesters when enable = 0 or when no req_valid bit is set.
- req_ready depends on req_valid. Requesters must hold req_valid and req_data stable until their handshake completes.
- last_grant updates to i only on a grant edge; otherwise it holds.
- Throughput is one grant per cycle. With all requesters valid, grants cycle 0,1,2,3,0,...

Issue:
- A grant of requester i in cycle c registers req_data slice i into tanh_in_data, held during cycle c+1.
- Cycles with no grant register 0 into tanh_in_data.

Tag pipeline:
- TANH_LATENCY+1 stages, each {valid, id[$clog2(NUM_REQ)-1:0]}. Stage 0 loads {grant, i} at every edge.
- At the last stage, resp_valid[id] = valid, combinationally decoded one-hot.
- resp_data = tanh_out_data when the last stage is valid, else 0.
- End-to-end latency is exactly TANH_LATENCY+1 cycles from the grant cycle; the response for grant cycle c appears in cycle c+1+TANH_LATENCY.
- Responses return in grant order, never reordered.

inflight_count:
- Incremented on grant, decremented when the last stage is valid.
- Grant and retire in the same cycle leave it unchanged.
- Maximum value is TANH_LATENCY+1, and it never wraps.

enable:
- Deasserting enable stops new grants only; the pipeline drains normally and busy falls after the last response.
- Reasserting enable resumes from the held last_grant.

Test Plan:
The bench tanh stub returns tanh_out_data = tanh_in_data[15:8] ^ 8'hA5 after exactly 5 cycles.
- Single request: requester 2 valid with 0x0300 in cycle 10 -> req_ready[2]=1 in cycle 10; tanh_in_data=0x0300 in cycle 11; resp_valid=4'b0100, resp_data=0xA6 in cycle 16; inflight_count 1 during cycles 11–16, 0 from cycle 17.
- All four requesters valid continuously from the first cycle after reset -> grants 0,1,2,3,0,1 on consecutive cycles; responses in the same order 6 cycles later; inflight_count saturates at 6.
- Requester 1 served in cycle 5, then requesters 0 and 1 both valid in cycle 6 -> requester 0 is granted first (pointer is past 1).
- enable dropped after 3 grants while requests remain -> no further req_ready; 3 responses still arrive; busy falls to 0 the cycle after the last response.
- reset asserted 2 cycles after 4 grants -> all outputs 0 immediately; no resp_valid ever appears for those 4 samples; after release, requester 0 has first priority.
- Back-to-back grant and retire in the same cycle -> inflight_count unchanged across that edge.

Source files
------------

// File: rtl/tanh_arbiter.sv
// Round-robin share of one fixed-latency tanh unit among NUM_REQ requesters; tags track in-flight samples.
// Latency grant->resp_valid = TANH_LATENCY+1 cycles; req_ready is the only backpressure, responses cannot stall.
module tanh_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_IN_W    = 16,
   parameter int DATA_OUT_W   = 8,
   parameter int TANH_LATENCY = 5
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                enable,
   input  logic [NUM_REQ-1:0]                  req_valid,
   input  logic [NUM_REQ*DATA_IN_W-1:0]        req_data,
   output logic [NUM_REQ-1:0]                  req_ready,
   output logic [DATA_IN_W-1:0]                tanh_in_data,
   input  logic [DATA_OUT_W-1:0]               tanh_out_data,
   output logic [NUM_REQ-1:0]                  resp_valid,
   output logic [DATA_OUT_W-1:0]               resp_data,
   output logic [$clog2(TANH_LATENCY+2)-1:0]   inflight_count,
   output logic                                busy
);

   localparam int ID_W   = $clog2(NUM_REQ);
   localparam int CNT_W  = $clog2(TANH_LATENCY+2);
   localparam int STAGES = TANH_LATENCY + 1;

   logic [ID_W-1:0]      last_grant;
   logic [ID_W-1:0]      cand;
   logic [ID_W-1:0]      gnt_id;
   logic                 grant;
   logic [DATA_IN_W-1:0] sel_data;
   logic [STAGES-1:0]    stg_vld;
   logic [ID_W-1:0]      stg_id [STAGES];
   logic                 retire;
   logic [ID_W-1:0]      ret_id;

   // Search starts just past the last winner so every requester gets a turn.
   always_comb begin
      grant  = 1'b0;
      gnt_id = '0;
      cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
         if (!grant && req_valid[cand]) begin
            grant  = 1'b1;
            gnt_id = cand;
         end
      end
      if (!enable || !reset) begin
         grant = 1'b0;
      end
      req_ready = grant ? (NUM_REQ'(1) << gnt_id) : '0;
   end

   assign sel_data = req_data[int'(gnt_id)*DATA_IN_W +: DATA_IN_W];

   assign retire     = stg_vld[STAGES-1];
   assign ret_id     = stg_id[STAGES-1];
   assign resp_valid = retire ? (NUM_REQ'(1) << ret_id) : '0;
   assign resp_data  = retire ? tanh_out_data : '0;
   assign busy       = (inflight_count != '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_grant     <= ID_W'(NUM_REQ-1);
         tanh_in_data   <= '0;
         stg_vld        <= '0;
         stg_id         <= '{default: '0};
         inflight_count <= '0;
      end else begin
         if (grant) begin
            last_grant <= gnt_id;
         end
         tanh_in_data <= grant ? sel_data : '0;
         stg_vld      <= {stg_vld[STAGES-2:0], grant};
         stg_id[0]    <= gnt_id;
         for (int k = 1; k < STAGES; k++) begin
            stg_id[k] <= stg_id[k-1];
         end
         // Bounded by the pipe depth: at most STAGES grants can be outstanding.
         case ({grant, retire})
            2'b10:   inflight_count <= inflight_count + CNT_W'(1);
            2'b01:   inflight_count <= inflight_count - CNT_W'(1);
            default: inflight_count <= inflight_count;
         endcase
      end
   end

endmodule
